// File: rtl/fancy_counter_pkg.sv
// Shared constants for the fancy counter family: the special-value table of
// the fancy transform and the direction encoding.
package fancy_counter_pkg;

   localparam int FANCY_IN0  = 0;
   localparam int FANCY_OUT0 = 17;
   localparam int FANCY_IN1  = 1;
   localparam int FANCY_OUT1 = 1287;
   localparam int FANCY_IN2  = 17;
   localparam int FANCY_OUT2 = 2137;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/fancy_delay_line.sv
// DELAY-stage shift register with synchronous reset; advances only when shift=1
// so that it tracks the counter's advances rather than raw clock cycles.
module fancy_delay_line #(
   parameter int WIDTH = 16,
   parameter int DELAY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DELAY];

   // NOTE: the stage array is tiny and its reset value is observable through
   // fancy_data, so every stage is reset rather than left as uninitialised memory.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DELAY; i++) stage[i] <= '0;
      end else if (shift) begin
         stage[0] <= din;
         for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DELAY-1];

endmodule

// File: rtl/fancy_counter_multi.sv
// Up/down loadable counter with wrap/saturate boundary handling, terminal-count
// strobe, sticky overflow and the fancy transform over the count and its delayed copy.
module fancy_counter_multi
   import fancy_counter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DELAY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] fancy_data,
   output logic             tc,
   output logic             ovf
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] delayed;
   logic             boundary;

   assign boundary = (dir == DIR_UP) ? (cnt == '1) : (cnt == '0);
   assign tc       = en & ~load & ~reset & boundary;

   // NOTE: every signal written here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_next = cnt;
      if (load) begin
         cnt_next = load_value;
      end else if (en) begin
         if (!boundary)
            cnt_next = (dir == DIR_UP) ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
         else if (!sat)
            cnt_next = (dir == DIR_UP) ? '0 : '1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         cnt <= cnt_next;
         if (tc)
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;
      end
   end

   // The delay line captures the pre-update count on every advance or load.
   fancy_delay_line #(
      .WIDTH (WIDTH),
      .DELAY (DELAY)
   ) u_delay (
      .clk   (clk),
      .reset (reset),
      .shift (load | en),
      .din   (cnt),
      .dout  (delayed)
   );

   always_comb begin
      fancy_data = (delayed ^ cnt) + cnt;
      if (cnt == WIDTH'(FANCY_IN0))
         fancy_data = WIDTH'(FANCY_OUT0);
      else if (cnt == WIDTH'(FANCY_IN1))
         fancy_data = WIDTH'(FANCY_OUT1);
      else if (cnt == WIDTH'(FANCY_IN2))
         fancy_data = WIDTH'(FANCY_OUT2);
   end

   assign data = cnt;

endmodule

// File: doc/fancy_counter_multi.md
Name: fancy_counter_multi

Overview:
Parametrised successor to the single-mode 16-bit fancy counter. Provides an up/down, loadable counter with a configurable delay line and a selectable wrap or saturate mode. Outputs the raw count, a "fancy" transform of the count and its delayed copy, a terminal-count strobe and a sticky overflow flag. Sits alongside the existing counter in the simulation test set and must reproduce its outputs exactly with default parameters, dir=0, sat=0, load=0.

Parameters:
WIDTH, 16, counter/data width in bits; legal range 12..32, because constant 2137 needs 12 bits.
DELAY, 1, depth of the delay line feeding the fancy transform; must be >= 1.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  advance enable
dir  input  1  0 = count up, 1 = count down
sat  input  1  0 = wrap at boundary, 1 = saturate at boundary
load  input  1  load cnt from load_value
load_value  input  WIDTH  value loaded when load=1
clr_ovf  input  1  clear sticky overflow flag
data  output  WIDTH  current count (cnt register)
fancy_data  output  WIDTH  combinational transform, defined below
tc  output  1  combinational terminal-count strobe
ovf  output  1  sticky overflow/saturation flag (registered)

Behaviour:
- Reset (reset=1 at clock edge): cnt=0, all DELAY delay stages=0, ovf=0. Reset overrides every other input. After reset: data=0, fancy_data=17, tc=0 unless en=1 and dir=1 (see tc).
- Priority per edge: reset > load > en > hold.
- load=1: cnt <= load_value, whatever en/dir/sat are. The delay line shifts. ovf is unchanged, except by clr_ovf.
- en=1, load=0:
  - Up (dir=0): cnt <= cnt+1, except at cnt = 2^WIDTH-1.
  - Down (dir=1): cnt <= cnt-1, except at cnt = 0.
  - At the boundary with sat=0: cnt wraps (max->0 up, 0->max down) and ovf is set.
  - At the boundary with sat=1: cnt holds and ovf is set.
  - The delay line shifts in all of these cases.
- en=0, load=0: cnt holds and the delay line holds.
- Delay line:
  - On each shift, stage[0] <= cnt (pre-update value) and stage[i] <= stage[i-1].
  - delayed = stage[DELAY-1].
  - With DELAY=1, delayed is the count one advance behind.
- fancy_data, combinational from data and delayed, priority order:
  - data==0 -> 17
  - data==1 -> 1287
  - data==17 -> 2137
  - else (delayed XOR data) + data, truncated modulo 2^WIDTH.
- tc = en & ~load & ~reset & ((dir=0 & cnt=max) | (dir=1 & cnt=0)). It is high in the cycle before the boundary event, regardless of sat.
- ovf:
  - Set on any edge where tc=1.
  - Cleared on an edge with clr_ovf=1 and tc=0.
  - If set and clear happen together, set wins.
- Direction change mid-run takes effect on the next advance, with no bubble.
- A reset asserted mid-run clears everything on that edge. Counting resumes from 0 on the first edge with reset=0 and en=1.

Decomposition:
- Package fancy_counter_pkg holds:
  - the special-value constants FANCY_IN0/OUT0 (0/17), FANCY_IN1/OUT1 (1/1287), FANCY_IN2/OUT2 (17/2137);
  - the dir encoding constants DIR_UP=0 and DIR_DOWN=1.
- Sub-module fancy_delay_line (params WIDTH, DELAY; ports clk, reset, shift, din, dout): a synchronous-reset shift register of DELAY stages.
- The top level holds the counter, the tc/ovf logic and the fancy transform.

Test Plan:
1. Backward compatibility (WIDTH=16, DELAY=1):
   - Stimulus: reset for 5 cycles, en=0 for 15 cycles, then en=1 for 65536+1078 cycles, reset for 20 cycles, then resume.
   - Required: data and fancy_data match a cycle-accurate behavioural model every cycle.
   - Spot values: at cnt=0, fancy=17; at cnt=1, fancy=1287; at cnt=17, fancy=2137; at cnt=5 (delayed=4), fancy=6.
2. Wrap up:
   - Stimulus: load 0xFFFE, then en=1, dir=0, sat=0 for 3 cycles.
   - Required: data 0xFFFF -> 0x0000 -> 0x0001; tc=1 only while data=0xFFFF; ovf rises after the wrap edge and stays high.
3. Saturate down:
   - Stimulus: load 2, then en=1, dir=1, sat=1 for 5 cycles.
   - Required: data 1 -> 0 -> 0 -> 0; tc=1 in every cycle at 0; ovf=1.
   - Then clr_ovf=1 with en=0: ovf=0 on the next edge.
4. Set beats clear:
   - Stimulus: data=0xFFFF, en=1, clr_ovf=1 on the same edge.
   - Required: ovf=1 after that edge.
5. Delay depth (DELAY=3, WIDTH=12):
   - Stimulus: after reset, en=1 counting up for 10 edges.
   - Required: at data=10, delayed=7, so fancy = (7 XOR 10)+10 = 23.
   - Then en=0 for 4 cycles: data and fancy_data are unchanged.
6. Reset and load priority:
   - Stimulus: reset=1 together with load=1, load_value=0x123, en=1.
   - Required: data=0, ovf=0, fancy=17.
   - Next edge with reset=0 and load=1: data=0x123, and the delay line's first stage holds 0.
